// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle radix-2 shift-add multiply controller for the EX stage.
// Stalls the front of the pipeline while the product is formed, then presents
// the low XLEN bits of the product for exactly one pipeline advance.
module mul_sequencer #(
  parameter int unsigned XLEN       = 32,
  parameter logic [3:0]  MUL_CTRL   = 4'b1010,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [3:0]      ALUCtrl_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q,  state_d;
  logic [XLEN-1:0] acc_q,    acc_d;
  logic [XLEN-1:0] mcand_q,  mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            start;
  logic [XLEN-1:0] acc_step;
  logic            last_step;

  // A MUL in EX that has not been squashed kicks off a new sequence.
  assign start = valid_i & (ALUCtrl_i == MUL_CTRL) & ~flush_i;

  // One shift-add step: accumulate when the current multiplier bit is set.
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Finish after XLEN steps, or once no multiplier bits remain to be consumed.
  assign last_step = (count_q == CNT_W'(1)) ||
                     (EARLY_EXIT && (mplier_q[XLEN-1:1] == '0));

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;
    stall_o  = 1'b0;
    done_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_o = start;
        if (start) begin
          acc_d    = '0;
          mcand_d  = data1_i;
          mplier_d = data2_i;
          count_d  = CNT_W'(XLEN);
          state_d  = S_BUSY;
        end
      end

      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          stall_o  = 1'b1;
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q - CNT_W'(1);
          if (last_step) begin
            result_d = acc_step;
            state_d  = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          done_o = 1'b1;
          // Pipeline advances unless frozen; the result is consumed exactly once.
          if (!hold_i) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == S_BUSY);
  assign result_o = result_q;

endmodule
